// File: rtl/veerwolf_board_io.sv
// Board I/O conditioning: switch synchronise/debounce with change pulse, and
// registered LED outputs gated by a global PWM brightness.

module veerwolf_board_io_db #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_nxt,
  output logic o_lvl
);
  logic [STABLE_SAMPLES-2:0] r_shreg;
  logic [STABLE_SAMPLES-1:0] w_win;
  logic                      r_lvl;

  // Oldest sample in the MSB; the current synchronised bit completes the window.
  assign w_win = {r_shreg, i_sync};

  always_comb begin
    o_nxt = r_lvl;
    if (i_tick) begin
      if (&w_win)       o_nxt = 1'b1;
      else if (~|w_win) o_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_lvl   <= 1'b0;
    end else begin
      r_lvl <= o_nxt;
      if (i_tick) r_shreg <= w_win[STABLE_SAMPLES-2:0];
    end
  end

  assign o_lvl = r_lvl;
endmodule

module veerwolf_board_io #(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STABLE_SAMPLES  = 3,
  parameter int PWM_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SW_WIDTH-1:0]  i_sw,
  output logic [SW_WIDTH-1:0]  o_sw,
  output logic                 o_sw_changed,
  input  logic [LED_WIDTH-1:0] i_led,
  input  logic [PWM_BITS-1:0]  i_led_duty,
  output logic [LED_WIDTH-1:0] o_led
);
  localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] r_sync;
  logic [SW_WIDTH-1:0]                  w_sync;
  logic [SW_WIDTH-1:0]                  w_sw_nxt;
  logic [PW-1:0]                        r_presc;
  logic                                 w_tick;
  logic                                 r_sw_changed;
  logic [PWM_BITS-1:0]                  r_pwm_cnt;
  logic                                 w_pwm_on;
  logic [LED_WIDTH-1:0]                 r_led;
  logic [LED_WIDTH-1:0]                 r_o_led;

  // Stage 0 captures the raw pins; the highest stage is the synchronised value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
  end
  assign w_sync = r_sync[SYNC_STAGES-1];

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_db
    veerwolf_board_io_db #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .clk    (clk),
      .rstn   (rstn),
      .i_tick (w_tick),
      .i_sync (w_sync[g]),
      .o_nxt  (w_sw_nxt[g]),
      .o_lvl  (o_sw[g])
    );
  end

  // Next level only differs from current on a tick, so this is one pulse per tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sw_changed <= 1'b0;
    else       r_sw_changed <= (w_sw_nxt != o_sw);
  end
  assign o_sw_changed = r_sw_changed;

  assign w_pwm_on = (&i_led_duty) | (r_pwm_cnt < i_led_duty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
      r_o_led   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= i_led;
      r_o_led   <= r_led & {LED_WIDTH{w_pwm_on}};
    end
  end
  assign o_led = r_o_led;
endmodule

// File: tb/tb_veerwolf_board_io.sv
// Scoreboard bench for veerwolf_board_io: expected o_sw values are queued by
// the stimulus and popped by a monitor whenever o_sw / o_sw_changed move.

module tb_veerwolf_board_io;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] i_sw = '0;
  logic [15:0] o_sw;
  logic        o_sw_changed;
  logic [15:0] i_led = '0;
  logic [3:0]  i_led_duty = '0;
  logic [15:0] o_led;

  veerwolf_board_io #(
    .SW_WIDTH(16), .LED_WIDTH(16), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .STABLE_SAMPLES(3), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rstn(rstn), .i_sw(i_sw), .o_sw(o_sw),
    .o_sw_changed(o_sw_changed), .i_led(i_led),
    .i_led_duty(i_led_duty), .o_led(o_led)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  int          last_pulse_e = 0;
  int          ecnt;
  logic [15:0] prev_sw = '0;
  logic [15:0] exp_q[$];

  // Edges since reset release.
  always @(posedge clk or negedge rstn)
    if (!rstn) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: any o_sw movement or change pulse is one scoreboard event.
  always @(negedge clk) begin
    if (!rstn) prev_sw = o_sw;
    else begin
      if (o_sw_changed || (o_sw !== prev_sw)) begin
        n_pulse++;
        last_pulse_e = ecnt;
        chk("pulse_with_level_change", {30'd0, o_sw_changed, o_sw !== prev_sw}, 32'd3);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: o_sw=%h changed=%b with nothing expected", o_sw, o_sw_changed);
        end else chk("sb_o_sw", {16'd0, o_sw}, {16'd0, exp_q.pop_front()});
      end
      prev_sw = o_sw;
    end
  end

  task automatic wait_pulse(input string nm, input int base);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      if (n_pulse > base) got = 1;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int base, c0, d, e;
    // Reset behaviour with LEDs requested fully on
    i_sw = 16'h0000; i_led = 16'hFFFF; i_led_duty = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_o_sw", {16'd0, o_sw}, 32'd0);
    chk("rst_changed", {31'd0, o_sw_changed}, 32'd0);
    chk("rst_o_led", {16'd0, o_led}, 32'd0);
    rstn = 1'b1;
    @(negedge clk); chk("led_cycle1", {16'd0, o_led}, 32'h0000);
    @(negedge clk); chk("led_cycle2", {16'd0, o_led}, 32'hFFFF);
    repeat (100) @(negedge clk);
    chk("no_pulse_idle", n_pulse, 0);

    // Clean rising step on bit 0
    c0 = ecnt; base = n_pulse;
    i_sw = 16'h0001; exp_q.push_back(16'h0001);
    wait_pulse("step_timeout", base);
    d = last_pulse_e - c0;
    chk("step_latency_in_11_14", {31'd0, (d >= 11 && d <= 14)}, 32'd1);
    repeat (20) @(negedge clk);
    chk("step_single_pulse", n_pulse, base + 1);

    // Glitch on bit 3 lasting 5 cycles
    base = n_pulse;
    i_sw = 16'h0009;
    repeat (5) @(negedge clk);
    i_sw = 16'h0001;
    repeat (30) @(negedge clk);
    chk("glitch_no_pulse", n_pulse, base);
    chk("glitch_o_sw", {16'd0, o_sw}, 32'h0001);

    // Bits 0 and 15 toggle together
    base = n_pulse;
    i_sw = 16'h8000; exp_q.push_back(16'h8000);
    wait_pulse("dual_timeout", base);
    repeat (20) @(negedge clk);
    chk("dual_one_pulse", n_pulse, base + 1);

    // LED PWM: duty 0, 8, 15
    i_led = 16'hA5A5; i_led_duty = 4'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); chk("pwm_duty0", {16'd0, o_led}, 32'd0);
    end
    i_led_duty = 4'd8;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("pwm_duty8", {16'd0, o_led}, (((ecnt - 1) % 16) < 8) ? 32'hA5A5 : 32'h0);
    end
    i_led_duty = 4'd15;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); chk("pwm_duty15", {16'd0, o_led}, 32'hA5A5);
    end

    // Reset while bit 2 holds two of three samples
    for (int i = 0; i < 8 && (ecnt % 4) != 0; i++) @(negedge clk);
    chk("tick_phase_found", ecnt % 4, 0);
    e = ecnt;
    i_sw = 16'h8004;
    repeat (9) @(negedge clk);
    chk("mid_debounce_o_sw", {16'd0, o_sw}, 32'h8000);
    rstn = 1'b0;
    #1;
    chk("async_rst_o_sw", {16'd0, o_sw}, 32'd0);
    chk("async_rst_o_led", {16'd0, o_led}, 32'd0);
    chk("async_rst_changed", {31'd0, o_sw_changed}, 32'd0);
    repeat (2) @(negedge clk);
    base = n_pulse;
    rstn = 1'b1; exp_q.push_back(16'h8004);
    wait_pulse("rerun_timeout", base);
    d = last_pulse_e;
    chk("rerun_latency_ge11", {31'd0, (d >= 11 && d <= 14)}, 32'd1);
    repeat (10) @(negedge clk);
    chk("sb_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/veerwolf_board_io.md
# veerwolf_board_io

Parametrised board I/O conditioning block for VeeRwolf FPGA toplevels. It sits between the physical switch/LED pins and the GPIO port of `veerwolf_core`. On the input side it synchronises and debounces N switch inputs and flags changes. On the output side it registers M LED outputs and applies a global PWM brightness. It replaces ad-hoc per-board two-flop switch and LED registers with one reusable block.

## Interface
Parameters:
- SW_WIDTH, 16: number of switch inputs.
- LED_WIDTH, 16: number of LED outputs.
- SYNC_STAGES, 2: synchroniser flops per switch bit; legal range ≥2.
- DEBOUNCE_CYCLES, 50000: clock cycles between debounce sample ticks; legal range ≥1.
- STABLE_SAMPLES, 3: consecutive equal samples required to accept a new level; legal range ≥2.
- PWM_BITS, 4: width of the PWM counter and of the duty input.

Ports:
- clk  in  1  core clock; the only clock.
- rstn  in  1  reset; asynchronous, active-low.
- i_sw  in  SW_WIDTH  raw asynchronous switch pins.
- o_sw  out  SW_WIDTH  debounced switch levels, to GPIO inputs.
- o_sw_changed  out  1  one-cycle pulse when any o_sw bit changes.
- i_led  in  LED_WIDTH  LED request from GPIO outputs.
- i_led_duty  in  PWM_BITS  global brightness; 0 = off, all-ones = always on.
- o_led  out  LED_WIDTH  registered LED pins.

## Operation
- Reset (rstn low, asynchronous): every flop clears to 0. This covers the synchroniser chains, sample shift registers, prescaler, PWM counter, LED pipeline, o_sw, o_sw_changed and o_led.
- Synchroniser: i_sw passes through SYNC_STAGES flops per bit. The last stage is `sync`.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1 and wraps to 0. `tick` is high for one cycle when the count equals DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, tick is high every cycle.
- Sampling: on a tick edge, each bit's shift register of depth STABLE_SAMPLES-1 shifts in `sync`.
- Acceptance: on the same tick edge, form the window {shreg, sync}.
  - All ones: o_sw bit ← 1.
  - All zeros: o_sw bit ← 0.
  - Mixed: o_sw bit holds.
- Bits are independent and may update on the same edge.
- o_sw_changed is registered on the tick edge as (next o_sw != current o_sw).
  - It is high in exactly the cycle o_sw shows its new value.
  - It is low otherwise, including non-tick cycles.
  - Several bits changing on one tick produce one pulse.
- Power-up: switches high at reset release drive o_sw to 1 and pulse o_sw_changed once STABLE_SAMPLES ticks have been taken. This is intended, so software sees the initial state.
- PWM counter: PWM_BITS wide, free-running, increments every cycle, wraps from all-ones to 0.
- PWM gate: pwm_on = (i_led_duty == all-ones) | (pwm_cnt < i_led_duty). Comparison is unsigned.
- LED path:
  - led_r ← i_led.
  - o_led ← led_r & {LED_WIDTH{pwm_on}}.
  - i_led_duty is used unregistered; a duty change affects o_led from the next edge.

## Timing
- i_sw to `sync`: SYNC_STAGES cycles.
- Clean switch step to o_sw update:
  - Minimum: SYNC_STAGES + (STABLE_SAMPLES-1)·DEBOUNCE_CYCLES + 1 cycles.
  - Maximum: SYNC_STAGES + STABLE_SAMPLES·DEBOUNCE_CYCLES cycles.
  - The exact value depends on prescaler phase.
- Glitch rejection: a pulse is always rejected when it is seen by `sync` for fewer than (STABLE_SAMPLES-1)·DEBOUNCE_CYCLES+1 cycles.
- Prescaler free-runs from reset and is never restarted by input activity.
- i_led to o_led at full duty: 2 cycles.
- PWM period: 2^PWM_BITS cycles. High time per period: duty cycles, or the full period when duty is all-ones.
- Reset mid-operation: outputs drop to 0 asynchronously. After rstn deasserts, the prescaler and PWM counter restart from 0 at the first clock edge. Partial debounce history is discarded.
- No backpressure or handshake; all outputs are plain registered levels or pulses.

## Test plan
Config for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STABLE_SAMPLES=3, PWM_BITS=4, widths 16.
- Reset with i_sw=0, i_led=0xFFFF, duty=15 held → o_sw=0, o_sw_changed=0, o_led=0 during reset. After release, o_led=0xFFFF from cycle 2; no change pulse for 100 cycles.
- i_sw 0x0000→0x0001 (clean) → o_sw=0x0001 between 11 and 14 cycles later. o_sw_changed is a single one-cycle pulse in that same cycle.
- i_sw[3] high for 5 cycles, then low → o_sw stays 0x0000, no pulse.
- i_sw bits 0 and 15 toggle in the same cycle → both update on the same edge; exactly one o_sw_changed pulse.
- i_led=0xA5A5 under different duties:
  - duty=0 → o_led=0 continuously.
  - duty=8 → o_led=0xA5A5 for 8 of every 16 cycles, aligned to pwm_cnt 0..7.
  - duty=15 → o_led=0xA5A5 constant.
- rstn pulsed low while i_sw[2] is mid-debounce (2 of 3 samples taken) → o_sw=0 immediately. After release, o_sw[2]=1 only after three fresh ticks (≥11 cycles).
